// File: rtl/gt_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gt_share_arbiter
// Description : Round-robin time-share controller for one external,
//               purely combinational WIDTH-bit greater-than comparator.
//               Four requesters compete. The winner's operand pair is latched
//               onto cmp_a/cmp_b and held for SETTLE_CYCLES cycles. Then
//               cmp_agtb is captured into result[i] and done[i] pulses for
//               one cycle.
// Ports       : clk        - system clock, rising edge
//               reset_n    - synchronous active-low reset
//               req[3:0]   - per-requester request level
//               a_flat     - operand a of requester i at [i*WIDTH +: WIDTH]
//               b_flat     - operand b of requester i at [i*WIDTH +: WIDTH]
//               gnt[3:0]   - one-hot grant, high while operands are on the bus
//               done[3:0]  - one-cycle result-valid pulse
//               result[3:0]- sticky per-requester (a_i > b_i)
//               busy       - high whenever the FSM is not idle
//               cmp_a/cmp_b- registered operands to the comparator
//               cmp_agtb   - comparator result (combinational from cmp_a/b)
// Revision    : 1.0 - initial release
// ============================================================================
module gt_share_arbiter #(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1    // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_flat,
    input  logic [4*WIDTH-1:0]   b_flat,
    output logic [3:0]           gnt,
    output logic [3:0]           done,
    output logic [3:0]           result,
    output logic                 busy,
    output logic [WIDTH-1:0]     cmp_a,
    output logic [WIDTH-1:0]     cmp_b,
    input  logic                 cmp_agtb
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // Counter load value: the capture happens on the edge where the
    // counter is already zero, so load one less than the hold time.
    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [1:0]       r_ptr;     // last requester served
    logic [1:0]       r_idx;     // requester currently being served
    logic [3:0]       r_gnt;
    logic [3:0]       r_done;
    logic [3:0]       r_result;
    logic             r_busy;
    logic [WIDTH-1:0] r_cmp_a;
    logic [WIDTH-1:0] r_cmp_b;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_a [4];
    logic [WIDTH-1:0] w_b [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_unpack
            assign w_a[g] = a_flat[g*WIDTH +: WIDTH];
            assign w_b[g] = b_flat[g*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (mod 4). The
    // 2-bit addition wraps naturally, so no explicit modulo is needed.
    // ------------------------------------------------------------------
    logic       w_found;
    logic [1:0] w_pick;
    logic [1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    logic [3:0] w_pick_onehot;
    logic [3:0] w_idx_onehot;

    assign w_pick_onehot = 4'b0001 << w_pick;
    assign w_idx_onehot  = 4'b0001 << r_idx;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_ptr    <= 2'd3;         // requester 0 wins first
            r_idx    <= 2'd0;
            r_gnt    <= 4'd0;
            r_done   <= 4'd0;
            r_result <= 4'd0;
            r_busy   <= 1'b0;
            r_cmp_a  <= '0;
            r_cmp_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Operands are sampled only here; later changes on
                        // a_flat/b_flat cannot disturb the comparison.
                        r_cmp_a <= w_a[w_pick];
                        r_cmp_b <= w_b[w_pick];
                        r_idx   <= w_pick;
                        r_gnt   <= w_pick_onehot;
                        r_cnt   <= C_SETTLE_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // A dropped req does not abort: the slot always completes.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_result[r_idx] <= cmp_agtb;
                        r_done          <= w_idx_onehot;
                        r_gnt           <= 4'd0;
                        r_ptr           <= r_idx;
                        r_state         <= S_RESP;
                    end
                end

                S_RESP: begin
                    // One dead cycle: no arbitration while done is shown.
                    r_done  <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_gnt   <= 4'd0;
                    r_done  <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign result = r_result;
    assign busy   = r_busy;
    assign cmp_a  = r_cmp_a;
    assign cmp_b  = r_cmp_b;

endmodule
`default_nettype wire

// File: doc/gt_share_arbiter.md
Name: gt_share_arbiter

Overview:
- Round-robin controller that shares one external WIDTH-bit greater-than comparator (gt_2_sop at WIDTH=2) among four requesters.
- The block selects one requester and latches its operand pair.
- It drives the pair onto the comparator bus and holds it for a programmable settle time.
- It then captures agtb and returns the result to the requester with a one-cycle done pulse.
- It sits between the comparison clients and the single comparator instance. The comparator stays purely combinational.

Parameters:
- WIDTH, 2, operand width of a, b and of the comparator bus.
- SETTLE_CYCLES, 1, number of cycles the operands are held on cmp_a/cmp_b before agtb is sampled. Legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  4  per-requester request level; bit i belongs to requester i.
- a_flat  input  4*WIDTH  operand a of requester i at bits [i*WIDTH +: WIDTH].
- b_flat  input  4*WIDTH  operand b of requester i at bits [i*WIDTH +: WIDTH].
- gnt  output  4  one-hot grant; high while requester i's operands are on the comparator bus.
- done  output  4  one-cycle pulse on bit i when requester i's result is valid.
- result  output  4  bit i = last captured (a_i > b_i); sticky until requester i is next served.
- busy  output  1  high in any state other than IDLE.
- cmp_a  output  WIDTH  registered operand a to the comparator.
- cmp_b  output  WIDTH  registered operand b to the comparator.
- cmp_agtb  input  1  comparator result, combinational from cmp_a/cmp_b.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE.
  - gnt=0, done=0, result=0, busy=0, cmp_a=0, cmp_b=0.
  - Settle counter=0.
  - Round-robin pointer ptr=3, so requester 0 has first priority.
  - Reset mid-transaction aborts it: no done pulse, result unchanged from reset value 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, at edge T with req != 0:
  - Pick idx as the first set bit in order ptr+1, ptr+2, ptr+3, ptr (all mod 4).
  - Latch cmp_a <= a_i and cmp_b <= b_i for i=idx.
  - Set gnt <= onehot(idx), counter <= SETTLE_CYCLES-1, state <= ISSUE.
  - With req == 0, stay in IDLE with all outputs held.
- ISSUE:
  - gnt and cmp_a/cmp_b are held stable.
  - While counter != 0, decrement the counter.
  - When counter == 0:
    - result[idx] <= cmp_agtb.
    - done <= onehot(idx).
    - gnt <= 0.
    - ptr <= idx.
    - state <= RESP.
- RESP:
  - done is high for exactly this one cycle; it clears on the next edge.
  - state <= IDLE.
  - No arbitration happens in RESP.
- Latency from the req-sampling edge T:
  - gnt is visible from T+1 to T+SETTLE_CYCLES.
  - done is visible in cycle T+SETTLE_CYCLES+1.
  - The earliest next grant is visible at T+SETTLE_CYCLES+3.
  - Service period is SETTLE_CYCLES+2 cycles per transaction.
- Handshake:
  - Operands are sampled only at the grant edge; later changes to a_flat/b_flat are ignored.
  - Deasserting req[idx] during ISSUE does not abort; the transaction completes and done still pulses.
  - A req bit still high when the FSM is back in IDLE is treated as a new request.
  - Requesters drop req on seeing done.
  - Only one gnt bit and at most one done bit are ever high.
- Fairness:
  - ptr updates only on capture.
  - With all four requesting continuously, grant order is 0,1,2,3,0,...
  - No requester waits more than 3 other transactions.
- Simultaneous events: a new req arriving in the same cycle another is captured is only considered in IDLE.
- Result bits of other requesters are never disturbed.

Test Plan:
- Reset, then req=4'b0001, a0=2'b10, b0=2'b01, SETTLE_CYCLES=1:
  - gnt=0001 in cycle T+1, cmp_a=10, cmp_b=01.
  - done=0001 in cycle T+2, result[0]=1, busy low at T+3.
- req=4'b1111, operand pairs (00,00), (01,00), (11,10), (10,11), req held high:
  - Grant order 0,1,2,3 then 0 again.
  - Results in order 0,1,1,0.
  - Next grant every 3 cycles from the sampling edge.
- Exhaustive sweep of 16 a/b pairs through requester 2 only:
  - result[2] is 1 exactly for (01,00), (10,00), (11,00), (10,01), (11,01), (11,10).
  - result[0], result[1] and result[3] stay 0.
- SETTLE_CYCLES=3, change a_flat right after the grant edge:
  - cmp_a unchanged for 3 cycles.
  - done at T+4 reflects the latched operands.
- Drop req[1] one cycle after gnt=0010:
  - done[1] still pulses.
  - No second grant to requester 1.
- Assert reset_n=0 during ISSUE:
  - Next cycle gnt=0, done=0, result=0, cmp_a=0, cmp_b=0.
  - The first grant after reset goes to requester 0 when all requesters request.
